// File: rtl/fifo_multi_channel.sv
// fifo_multi_channel: first-word fall-through FIFO holding NUM_CHANNELS independent queues of DEPTH entries
//
// Ports:
//   clk                     clock, all state updates on the rising edge
//   reset                   synchronous, active-low reset (contents discarded, storage not cleared)
//   i__data_in_valid        push request
//   i__data_in_channel      target channel of the push (out-of-range ids are dropped)
//   i__data_in              push payload
//   o__data_in_ready        per-channel "can accept this cycle", from registered state only
//   o__data_in_ready__next  value o__data_in_ready takes after the coming edge
//   o__data_out_valid       per-channel non-empty
//   i__data_out_channel     channel presented on o__data_out
//   o__data_out             head entry of the selected channel, 0 when empty or out of range
//   i__data_out_ready       pop the selected channel
//   o__occupancy            per-channel entry count, channel c at [c*CNT_WIDTH +: CNT_WIDTH]
//   o__almost_full          per-channel occupancy >= AFULL_THRESH
//   i__clear                per-channel synchronous flush, overrides push and pop on that channel
//
// Optional: define FIFO_MULTI_CHANNEL_BYPASS_EN to let a push into the empty selected channel
// go straight to o__data_out when it coincides with a pop.
module fifo_multi_channel #(
   parameter int DATA_WIDTH   = 64,
   parameter int DEPTH        = 3,
   parameter int NUM_CHANNELS = 4,
   parameter int AFULL_THRESH = DEPTH - 1,
   localparam int CH_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int ADDR_WIDTH  = $clog2(DEPTH),
   localparam int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            i__data_in_valid,
   input  logic [CH_WIDTH-1:0]             i__data_in_channel,
   input  logic [DATA_WIDTH-1:0]           i__data_in,
   output logic [NUM_CHANNELS-1:0]         o__data_in_ready,
   output logic [NUM_CHANNELS-1:0]         o__data_in_ready__next,
   output logic [NUM_CHANNELS-1:0]         o__data_out_valid,
   input  logic [CH_WIDTH-1:0]             i__data_out_channel,
   output logic [DATA_WIDTH-1:0]           o__data_out,
   input  logic                            i__data_out_ready,
   output logic [NUM_CHANNELS*CNT_WIDTH-1:0] o__occupancy,
   output logic [NUM_CHANNELS-1:0]         o__almost_full,
   input  logic [NUM_CHANNELS-1:0]         i__clear
);
   logic [DATA_WIDTH-1:0] r_mem    [NUM_CHANNELS][DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr [NUM_CHANNELS];
   logic [ADDR_WIDTH-1:0] r_rd_ptr [NUM_CHANNELS];
   logic [CNT_WIDTH-1:0]  r_cnt    [NUM_CHANNELS];
   logic [CNT_WIDTH-1:0]  w_cnt_next [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] w_sel, w_push_req, w_push, w_pop, w_byp;
   // Channel decode by equality: an out-of-range id matches no channel, so it neither pushes nor selects.
   always_comb begin
      w_sel                  = '0;
      w_push_req             = '0;
      w_push                 = '0;
      w_pop                  = '0;
      w_byp                  = '0;
      o__data_in_ready       = '0;
      o__data_in_ready__next = '0;
      o__data_out_valid      = '0;
      o__almost_full         = '0;
      o__occupancy           = '0;
      o__data_out            = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         w_sel[c]            = i__data_out_channel == CH_WIDTH'(c);
         w_push_req[c]       = i__data_in_valid && i__data_in_channel == CH_WIDTH'(c) && !i__clear[c];
         o__data_in_ready[c] = r_cnt[c] < CNT_WIDTH'(DEPTH);
`ifdef FIFO_MULTI_CHANNEL_BYPASS_EN
         w_byp[c]            = w_push_req[c] && w_sel[c] && i__data_out_ready && r_cnt[c] == '0;
`else
         w_byp[c]            = 1'b0;
`endif
         // A bypassed word is pushed and popped in the same cycle, so it never touches storage.
         w_push[c]           = w_push_req[c] && o__data_in_ready[c] && !w_byp[c];
         w_pop[c]            = w_sel[c] && i__data_out_ready && r_cnt[c] != '0 && !i__clear[c];
         w_cnt_next[c]       = (!reset || i__clear[c]) ? '0
                             : r_cnt[c] + CNT_WIDTH'(w_push[c]) - CNT_WIDTH'(w_pop[c]);
         o__data_in_ready__next[c] = w_cnt_next[c] < CNT_WIDTH'(DEPTH);
         o__data_out_valid[c] = r_cnt[c] != '0 || w_byp[c];
         o__almost_full[c]    = 32'(r_cnt[c]) >= AFULL_THRESH;
         o__occupancy[c*CNT_WIDTH +: CNT_WIDTH] = r_cnt[c];
         if (w_sel[c] && o__data_out_valid[c])
            o__data_out = w_byp[c] ? i__data_in : r_mem[c][r_rd_ptr[c]];
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            r_cnt[c]    <= '0;
            r_wr_ptr[c] <= '0;
            r_rd_ptr[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            r_cnt[c] <= w_cnt_next[c];
            if (i__clear[c]) begin
               r_wr_ptr[c] <= '0;
               r_rd_ptr[c] <= '0;
            end else begin
               if (w_push[c])
                  r_wr_ptr[c] <= (r_wr_ptr[c] == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_wr_ptr[c] + ADDR_WIDTH'(1);
               if (w_pop[c])
                  r_rd_ptr[c] <= (r_rd_ptr[c] == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_rd_ptr[c] + ADDR_WIDTH'(1);
            end
         end
      end
   end
   // Storage has no reset; stale words are unreachable once the pointers and counts are cleared.
   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
         if (reset && w_push[c])
            r_mem[c][r_wr_ptr[c]] <= i__data_in;
   end
endmodule

// File: tb/tb_fifo_multi_channel.sv
// tb_fifo_multi_channel: directed vector table plus randomized traffic checked against a queue model
module tb_fifo_multi_channel;
   logic        clk = 1'b0;
   logic        rst_n, vin, ordy;
   logic [1:0]  ch, sel;
   logic [63:0] din, dout;
   logic [3:0]  clr, rdy, rdy_nx, vld, af;
   logic [7:0]  occ;
   int          checks = 0;
   int          errors = 0;
   bit          prechk = 0;
   logic [63:0] mq [4][$];

   typedef struct {
      logic r, v; logic [1:0] c; logic [63:0] d; logic [1:0] s; logic o; logic [3:0] cl;
      logic [7:0] occ; logic [3:0] rdy; logic [3:0] af; logic [63:0] dout;
   } vec_t;
   vec_t tv [26];

   fifo_multi_channel dut (
      .clk(clk), .reset(rst_n),
      .i__data_in_valid(vin), .i__data_in_channel(ch), .i__data_in(din),
      .o__data_in_ready(rdy), .o__data_in_ready__next(rdy_nx), .o__data_out_valid(vld),
      .i__data_out_channel(sel), .o__data_out(dout), .i__data_out_ready(ordy),
      .o__occupancy(occ), .o__almost_full(af), .i__clear(clr)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Pre-edge view of the rules: what the current inputs do to the current queue contents.
   task automatic model_flags(output bit pu, output bit po, output bit by);
      by = 0;
`ifdef FIFO_MULTI_CHANNEL_BYPASS_EN
      by = vin && ordy && ch == sel && !clr[ch] && mq[ch].size() == 0;
`endif
      pu = vin && !clr[ch] && mq[ch].size() < 3 && !by;
      po = ordy && !clr[sel] && mq[sel].size() > 0;
   endtask

   task automatic exp_out(output logic [3:0] ev, output logic [63:0] ed);
      bit pu, po, by;
      model_flags(pu, po, by);
      for (int c = 0; c < 4; c++) ev[c] = mq[c].size() != 0 || (by && sel == c);
      ed = by ? din : (mq[sel].size() != 0 ? mq[sel][0] : 64'h0);
   endtask

   task automatic check_state();
      logic [3:0] ev, er, ea; logic [7:0] eo; logic [63:0] ed;
      exp_out(ev, ed);
      for (int c = 0; c < 4; c++) begin
         er[c] = mq[c].size() < 3;
         ea[c] = mq[c].size() >= 2;
         eo[c*2 +: 2] = 2'(mq[c].size());
      end
      chk("model_ready", rdy, er);
      chk("model_valid", vld, ev);
      chk("model_occ", occ, eo);
      chk("model_afull", af, ea);
      chk("model_dout", dout, ed);
   endtask

   task automatic step(input bit r, input bit v, input logic [1:0] c_in, input logic [63:0] d,
                       input logic [1:0] s, input bit o, input logic [3:0] cl);
      bit pu, po, by; logic [3:0] enx, ev; logic [63:0] ed; int n;
      rst_n = r; vin = v; ch = c_in; din = d; sel = s; ordy = o; clr = cl;
      #1;
      model_flags(pu, po, by);
      for (int c = 0; c < 4; c++) begin
         n = (!rst_n || clr[c]) ? 0 : mq[c].size() + int'(pu && ch == c) - int'(po && sel == c);
         enx[c] = n < 3;
      end
      exp_out(ev, ed);
      chk("ready_next", rdy_nx, enx);
      if (prechk) begin
         chk("comb_valid", vld, ev);
         chk("comb_dout", dout, ed);
      end
      if (!rst_n) begin
         for (int c = 0; c < 4; c++) mq[c].delete();
      end else begin
         for (int c = 0; c < 4; c++) if (clr[c]) mq[c].delete();
         if (po) void'(mq[sel].pop_front());
         if (pu) mq[ch].push_back(din);
      end
      @(posedge clk);
      #1;
      check_state();
      prechk = 1;
   endtask

   initial begin
      logic [3:0] rc;
      tv[0]  = '{0,0,0,64'h0 ,2,0,4'h0, 8'h00,4'hF,4'h0,64'h0};
      tv[1]  = '{1,1,2,64'hA1,2,0,4'h0, 8'h10,4'hF,4'h0,64'hA1};
      tv[2]  = '{1,1,2,64'hA2,2,0,4'h0, 8'h20,4'hF,4'h4,64'hA1};
      tv[3]  = '{1,1,2,64'hA3,2,0,4'h0, 8'h30,4'hB,4'h4,64'hA1};
      tv[4]  = '{1,1,2,64'hA4,2,0,4'h0, 8'h30,4'hB,4'h4,64'hA1};
      tv[5]  = '{1,0,0,64'h0 ,2,1,4'h0, 8'h20,4'hF,4'h4,64'hA2};
      tv[6]  = '{1,0,0,64'h0 ,2,1,4'h0, 8'h10,4'hF,4'h0,64'hA3};
      tv[7]  = '{1,0,0,64'h0 ,2,1,4'h0, 8'h00,4'hF,4'h0,64'h0};
      tv[8]  = '{1,0,0,64'h0 ,2,1,4'h0, 8'h00,4'hF,4'h0,64'h0};
      tv[9]  = '{1,1,2,64'hB1,2,0,4'h0, 8'h10,4'hF,4'h0,64'hB1};
      tv[10] = '{1,1,2,64'hB2,2,1,4'h0, 8'h10,4'hF,4'h0,64'hB2};
      tv[11] = '{1,1,2,64'hB3,2,0,4'h0, 8'h20,4'hF,4'h4,64'hB2};
      tv[12] = '{1,0,0,64'h0 ,2,1,4'h0, 8'h10,4'hF,4'h0,64'hB3};
      tv[13] = '{1,0,0,64'h0 ,2,1,4'h0, 8'h00,4'hF,4'h0,64'h0};
      tv[14] = '{1,1,1,64'h22,1,0,4'h0, 8'h04,4'hF,4'h0,64'h22};
      tv[15] = '{1,1,0,64'h11,1,1,4'h0, 8'h01,4'hF,4'h0,64'h0};
      tv[16] = '{1,1,3,64'h31,3,0,4'h0, 8'h41,4'hF,4'h0,64'h31};
      tv[17] = '{1,1,3,64'h32,3,0,4'h0, 8'h81,4'hF,4'h8,64'h31};
      tv[18] = '{1,1,3,64'h33,3,0,4'h0, 8'hC1,4'h7,4'h8,64'h31};
      tv[19] = '{1,1,3,64'h34,3,1,4'h0, 8'h81,4'hF,4'h8,64'h32};
      tv[20] = '{1,1,1,64'h41,1,0,4'h0, 8'h85,4'hF,4'h8,64'h41};
      tv[21] = '{1,1,1,64'h42,1,0,4'h0, 8'h89,4'hF,4'hA,64'h41};
      tv[22] = '{1,1,1,64'h43,1,1,4'h2, 8'h81,4'hF,4'h8,64'h0};
      tv[23] = '{1,1,2,64'h51,0,0,4'h0, 8'h91,4'hF,4'h8,64'h11};
      tv[24] = '{1,1,1,64'h61,0,0,4'h0, 8'h95,4'hF,4'h8,64'h11};
      tv[25] = '{0,0,0,64'h0 ,0,0,4'h0, 8'h00,4'hF,4'h0,64'h0};

      for (int i = 0; i < 26; i++) begin
         step(tv[i].r, tv[i].v, tv[i].c, tv[i].d, tv[i].s, tv[i].o, tv[i].cl);
         chk($sformatf("vec%0d_occ", i), occ, tv[i].occ);
         chk($sformatf("vec%0d_ready", i), rdy, tv[i].rdy);
         chk($sformatf("vec%0d_afull", i), af, tv[i].af);
         chk($sformatf("vec%0d_dout", i), dout, tv[i].dout);
         chk($sformatf("vec%0d_valid", i), vld, {occ[7:6] != 0, occ[5:4] != 0, occ[3:2] != 0, occ[1:0] != 0});
      end

      for (int i = 0; i < 1000; i++) begin
         for (int b = 0; b < 4; b++) rc[b] = $urandom_range(0, 24) == 0;
         step($urandom_range(0, 79) != 0, $urandom_range(0, 9) < 6, 2'($urandom),
              {$urandom, $urandom}, 2'($urandom), 1'($urandom), rc);
      end

`ifdef FIFO_MULTI_CHANNEL_BYPASS_EN
      step(0, 0, 0, 64'h0, 0, 0, 4'h0);
      rst_n = 1; vin = 1; ch = 0; din = 64'h5A; sel = 0; ordy = 1; clr = 0;
      #1;
      chk("bypass_dout", dout, 64'h5A);
      chk("bypass_valid", vld[0], 1'b1);
      step(1, 1, 0, 64'h5A, 0, 1, 4'h0);
      chk("bypass_occ", occ[1:0], 2'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
